// File: rtl/dm_pkg.sv
// DMI transport types shared by the DTM, the arbiter and the debug module.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_arbiter_fifo.sv
// Outstanding-ID FIFO: remembers which master issued each request still
// awaiting a DM response, so responses route back in issue order.
module dmi_arbiter_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        push     = push_i & ~full_o;
        pop      = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DMI target port between NumReq masters: round-robin request
// arbitration with grant locking while stalled, in-order response routing.
module dmi_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  dm::dmi_req_t [NumReq-1:0]  req_i,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    output dm::dmi_resp_t              resp_o,
    output logic [NumReq-1:0]          resp_valid_o,
    input  logic [NumReq-1:0]          resp_ready_i,
    output dm::dmi_req_t               dmi_req_o,
    output logic                       dmi_req_valid_o,
    input  logic                       dmi_req_ready_i,
    input  dm::dmi_resp_t              dmi_resp_i,
    input  logic                       dmi_resp_valid_i,
    output logic                       dmi_resp_ready_o,
    output logic                       spurious_resp_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lockidx_q, lockidx_d;
    logic [IdxW-1:0] grant;
    logic [IdxW-1:0] head;
    logic            req_hs;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;

    // First valid requester at or after start, wrapping modulo NumReq.
    function automatic logic [IdxW-1:0] rr_search(input logic [NumReq-1:0] valid,
                                                  input logic [IdxW-1:0]   start);
        logic [IdxW-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = start;
        found = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = (32'(start) + i) % NumReq;
            if (!found && valid[IdxW'(idx)]) begin
                pick  = IdxW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Request side: grant selection, issue gating and lock/round-robin update.
    always_comb begin
        grant           = lock_q ? lockidx_q : rr_search(req_valid_i, rr_q);
        dmi_req_valid_o = req_valid_i[grant] & ~fifo_full;
        dmi_req_o       = req_i[grant];
        req_ready_o     = '0;
        req_ready_o[grant] = dmi_req_ready_i & ~fifo_full;
        req_hs          = dmi_req_valid_o & dmi_req_ready_i;
        rr_d            = rr_q;
        lock_d          = lock_q;
        lockidx_d       = lockidx_q;
        if (req_hs) begin
            rr_d   = (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
            lock_d = 1'b0;
        end else if (dmi_req_valid_o) begin
            lock_d    = 1'b1;
            lockidx_d = grant;
        end
    end

    // Response side: route to the FIFO head, or drain as spurious when empty.
    always_comb begin
        resp_o           = dmi_resp_i;
        resp_valid_o     = '0;
        dmi_resp_ready_o = 1'b1;
        spurious_resp_o  = 1'b0;
        fifo_pop         = 1'b0;
        if (fifo_empty) begin
            spurious_resp_o = dmi_resp_valid_i;
        end else begin
            resp_valid_o[head] = dmi_resp_valid_i;
            dmi_resp_ready_o   = resp_ready_i[head];
            fifo_pop           = dmi_resp_valid_i & resp_ready_i[head];
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lockidx_q <= '0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lockidx_q <= lockidx_d;
        end
    end

    dmi_arbiter_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_hs),
        .data_i  (grant),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter with scoreboard queues for DM-side request
// handshakes and master-side response handshakes.
module tb_dmi_arbiter;

    typedef struct packed {
        logic        idx;
        logic [31:0] data;
    } resp_exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    dm::dmi_req_t [1:0]   req;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    dm::dmi_resp_t        resp;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    dm::dmi_req_t         dmi_req;
    logic                 dmi_req_valid;
    logic                 dmi_req_ready;
    dm::dmi_resp_t        dmi_resp;
    logic                 dmi_resp_valid;
    logic                 dmi_resp_ready;
    logic                 spurious;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_req_q[$];
    resp_exp_t  exp_resp_q[$];

    always #5 clk = ~clk;

    dmi_arbiter #(
        .NumReq         (2),
        .MaxOutstanding (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .resp_o           (resp),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .dmi_req_o        (dmi_req),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_resp_i       (dmi_resp),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready),
        .spurious_resp_o  (spurious)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Request monitor: every DM-side handshake must match the next expected address.
    always @(negedge clk) begin : req_mon
        logic [6:0] e;
        if (rst_n && dmi_req_valid && dmi_req_ready) begin
            if (exp_req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: got addr %0h expected no request", dmi_req.addr);
            end else begin
                e = exp_req_q.pop_front();
                check("dmi_req_addr", 64'(dmi_req.addr), 64'(e));
            end
        end
    end

    // Response monitor: every master-side response handshake must match the next expected one.
    always @(negedge clk) begin : resp_mon
        resp_exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rst_n && resp_valid[i] && resp_ready[i]) begin
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got master %0d data %0h expected none", i, resp.data);
                end else begin
                    e = exp_resp_q.pop_front();
                    check("resp_master", 64'(i), 64'(e.idx));
                    check("resp_data", 64'(resp.data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        req            = '0;
        req_valid      = 2'b00;
        resp_ready     = 2'b11;
        dmi_req_ready  = 1'b0;
        dmi_resp       = '0;
        dmi_resp_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(2'b00));
        check("rst_dmi_req_valid", 64'(dmi_req_valid), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(2'b00));
        check("rst_dmi_resp_ready", 64'(dmi_resp_ready), 64'(1));
        check("rst_spurious", 64'(spurious), 64'(0));
        next_cycle();
        rst_n = 1'b1;

        // 1: single master read, response next cycle
        next_cycle();
        req[0].addr   = 7'h11;
        req[0].op     = dm::DTM_READ;
        req_valid     = 2'b01;
        dmi_req_ready = 1'b1;
        exp_req_q.push_back(7'h11);
        @(negedge clk);
        check("t1_req_ready", 64'(req_ready), 64'(2'b01));
        check("t1_dmi_req_valid", 64'(dmi_req_valid), 64'(1));
        next_cycle();
        req_valid      = 2'b00;
        dmi_resp_valid = 1'b1;
        dmi_resp.data  = 32'hDEADBEEF;
        exp_resp_q.push_back('{idx: 1'b0, data: 32'hDEADBEEF});
        @(negedge clk);
        check("t1_resp_valid", 64'(resp_valid), 64'(2'b01));
        check("t1_spurious", 64'(spurious), 64'(0));
        check("t1_dmi_resp_ready", 64'(dmi_resp_ready), 64'(1));
        next_cycle();
        dmi_resp_valid = 1'b0;

        // 2: both masters valid; rr starts at 1 so m1 (0x10) goes first
        req[0].addr = 7'h04;
        req[1].addr = 7'h10;
        req[1].op   = dm::DTM_READ;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            if (k < 4) begin
                req_valid = 2'b11;
                exp_req_q.push_back((k % 2 == 0) ? 7'h10 : 7'h04);
            end else begin
                req_valid = 2'b00;
            end
            if (k >= 1) begin
                dmi_resp_valid = 1'b1;
                dmi_resp.data  = 32'hC000_0000 + 32'(k);
                exp_resp_q.push_back('{idx: ((k - 1) % 2 == 0) ? 1'b1 : 1'b0,
                                       data: 32'hC000_0000 + 32'(k)});
            end
            @(negedge clk);
            if (k < 4) check("t2_dmi_req_valid", 64'(dmi_req_valid), 64'(1));
        end
        next_cycle();
        dmi_resp_valid = 1'b0;

        // 3: lock holds m0 while DM stalls, even after m1 asserts
        req[0].addr   = 7'h17;
        req_valid     = 2'b01;
        dmi_req_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) next_cycle();
            if (j == 1) req_valid = 2'b11;
            @(negedge clk);
            check("t3_lock_addr", 64'(dmi_req.addr), 64'(7'h17));
            check("t3_lock_valid", 64'(dmi_req_valid), 64'(1));
            check("t3_lock_ready", 64'(req_ready), 64'(2'b00));
        end
        next_cycle();
        dmi_req_ready = 1'b1;
        exp_req_q.push_back(7'h17);
        @(negedge clk);
        check("t3_m0_ready", 64'(req_ready), 64'(2'b01));
        next_cycle();
        req_valid = 2'b10;
        exp_req_q.push_back(7'h10);
        @(negedge clk);
        check("t3_m1_ready", 64'(req_ready), 64'(2'b10));
        next_cycle();
        req_valid      = 2'b00;
        dmi_resp_valid = 1'b1;
        dmi_resp.data  = 32'h1;
        exp_resp_q.push_back('{idx: 1'b0, data: 32'h1});
        next_cycle();
        dmi_resp.data = 32'h2;
        exp_resp_q.push_back('{idx: 1'b1, data: 32'h2});
        next_cycle();
        dmi_resp_valid = 1'b0;

        // 4: full blocks issue, including the cycle a response pops
        req[0].addr = 7'h20;
        req_valid   = 2'b01;
        exp_req_q.push_back(7'h20);
        next_cycle();
        req[1].addr = 7'h21;
        req_valid   = 2'b10;
        exp_req_q.push_back(7'h21);
        next_cycle();
        req[1].addr = 7'h23;
        @(negedge clk);
        check("t4_full_valid", 64'(dmi_req_valid), 64'(0));
        check("t4_full_ready", 64'(req_ready), 64'(2'b00));
        next_cycle();
        dmi_resp_valid = 1'b1;
        dmi_resp.data  = 32'hA0;
        exp_resp_q.push_back('{idx: 1'b0, data: 32'hA0});
        @(negedge clk);
        check("t4_pop_cycle_valid", 64'(dmi_req_valid), 64'(0));
        check("t4_pop_resp_valid", 64'(resp_valid), 64'(2'b01));
        next_cycle();
        dmi_resp_valid = 1'b0;
        exp_req_q.push_back(7'h23);
        @(negedge clk);
        check("t4_resume_valid", 64'(dmi_req_valid), 64'(1));

        // 5: response backpressure from head master m1
        next_cycle();
        req_valid      = 2'b00;
        resp_ready     = 2'b01;
        dmi_resp_valid = 1'b1;
        dmi_resp.data  = 32'hB1;
        for (int j = 0; j < 2; j++) begin
            if (j > 0) next_cycle();
            @(negedge clk);
            check("t5_dmi_resp_ready", 64'(dmi_resp_ready), 64'(0));
            check("t5_resp_valid", 64'(resp_valid), 64'(2'b10));
        end
        next_cycle();
        resp_ready = 2'b11;
        exp_resp_q.push_back('{idx: 1'b1, data: 32'hB1});
        @(negedge clk);
        check("t5_release_ready", 64'(dmi_resp_ready), 64'(1));
        next_cycle();
        dmi_resp_valid = 1'b0;

        // 6: reset with two outstanding, then a late DM response is spurious
        req[0].addr = 7'h30;
        req_valid   = 2'b01;
        exp_req_q.push_back(7'h30);
        next_cycle();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        @(negedge clk);
        check("t6_rst_resp_ready", 64'(dmi_resp_ready), 64'(1));
        check("t6_rst_resp_valid", 64'(resp_valid), 64'(2'b00));
        next_cycle();
        rst_n          = 1'b1;
        dmi_resp_valid = 1'b1;
        dmi_resp.data  = 32'hE0;
        @(negedge clk);
        check("t6_spurious", 64'(spurious), 64'(1));
        check("t6_resp_valid", 64'(resp_valid), 64'(2'b00));
        check("t6_dmi_resp_ready", 64'(dmi_resp_ready), 64'(1));
        next_cycle();
        dmi_resp_valid = 1'b0;
        @(negedge clk);
        check("t6_spurious_pulse", 64'(spurious), 64'(0));

        // Every expected handshake must have been observed
        check("req_queue_drained", 64'(exp_req_q.size()), 64'(0));
        check("resp_queue_drained", 64'(exp_resp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
